// File: rtl/not_output_a_if.sv
// rtl/not_output_a_if.sv - operand/result bundle for not_output_a
interface not_output_a_if #(
  parameter int WIDTH    = 8,
  parameter int IN_WIDTH = WIDTH
);
  logic [IN_WIDTH-1:0] a;
  logic                op;
  logic                in_valid;
  logic [WIDTH-1:0]    not_y;
  logic [WIDTH-1:0]    out_y;
  logic [WIDTH-1:0]    q;
  logic                q_valid;

  modport master (
    output a, op, in_valid,
    input  not_y, out_y, q, q_valid
  );

  modport slave (
    input  a, op, in_valid,
    output not_y, out_y, q, q_valid
  );
endinterface

// File: rtl/not_output_a.sv
// rtl/not_output_a.sv - width-adapting pass/invert with one registered, selectable result
module not_output_a #(
  parameter int WIDTH    = 8,
  parameter int IN_WIDTH = WIDTH
) (
  input logic           clk,
  input logic           rst,
  not_output_a_if.slave bus
);
  logic [WIDTH-1:0] a_ext;
  logic [WIDTH-1:0] q_r;
  logic             q_valid_r;

  generate
    if (IN_WIDTH < WIDTH) begin : g_zext
      assign a_ext = {{(WIDTH - IN_WIDTH){1'b0}}, bus.a};
    end else if (IN_WIDTH > WIDTH) begin : g_trunc
      // Upper operand bits are intentionally dropped.
      logic unused_hi;
      assign unused_hi = ^bus.a[IN_WIDTH-1:WIDTH];
      assign a_ext     = bus.a[WIDTH-1:0];
    end else begin : g_same
      assign a_ext = bus.a;
    end
  endgenerate

  assign bus.out_y = a_ext;
  assign bus.not_y = ~a_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r       <= '0;
      q_valid_r <= 1'b0;
    end else begin
      q_valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        q_r <= bus.op ? ~a_ext : a_ext;
      end
    end
  end

  assign bus.q       = q_r;
  assign bus.q_valid = q_valid_r;
endmodule

// File: tb/tb_not_output_a.sv
// tb/tb_not_output_a.sv - randomized and directed checks of not_output_a in three width configurations
module tb_not_output_a;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] a16 = '0;
  logic        op  = 1'b0;
  logic        vld = 1'b0;

  int compared   = 0;
  int mismatched = 0;

  // Instance 0: 8/8, instance 1: 32 result from 8 operand, instance 2: 8 result from 16 operand.
  int          w_of[3]  = '{8, 32, 8};
  int          iw_of[3] = '{8, 8, 16};
  logic [63:0] exp_q[3];
  logic        exp_v[3];

  not_output_a_if #(.WIDTH(8),  .IN_WIDTH(8))  if0 ();
  not_output_a_if #(.WIDTH(32), .IN_WIDTH(8))  if1 ();
  not_output_a_if #(.WIDTH(8),  .IN_WIDTH(16)) if2 ();

  assign if0.a = a16[7:0];
  assign if1.a = a16[7:0];
  assign if2.a = a16;
  assign if0.op = op;
  assign if1.op = op;
  assign if2.op = op;
  assign if0.in_valid = vld;
  assign if1.in_valid = vld;
  assign if2.in_valid = vld;

  not_output_a #(.WIDTH(8),  .IN_WIDTH(8))  dut0 (.clk(clk), .rst(rst), .bus(if0));
  not_output_a #(.WIDTH(32), .IN_WIDTH(8))  dut1 (.clk(clk), .rst(rst), .bus(if1));
  not_output_a #(.WIDTH(8),  .IN_WIDTH(16)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  always #5 clk = ~clk;

  function automatic logic [63:0] mask(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [63:0] ext_of(input int k, input logic [15:0] av);
    return ({48'd0, av} & mask(iw_of[k])) & mask(w_of[k]);
  endfunction

  function automatic logic [63:0] inv_of(input int k, input logic [15:0] av);
    return mask(w_of[k]) - ext_of(k, av);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic get_obs(input int k, output logic [63:0] oy, output logic [63:0] ny,
                         output logic [63:0] qq, output logic qv);
    case (k)
      0: begin oy = 64'(if0.out_y); ny = 64'(if0.not_y); qq = 64'(if0.q); qv = if0.q_valid; end
      1: begin oy = 64'(if1.out_y); ny = 64'(if1.not_y); qq = 64'(if1.q); qv = if1.q_valid; end
      default: begin oy = 64'(if2.out_y); ny = 64'(if2.not_y); qq = 64'(if2.q); qv = if2.q_valid; end
    endcase
  endtask

  task automatic check_comb(input string tag);
    logic [63:0] oy, ny, qq;
    logic qv;
    for (int k = 0; k < 3; k++) begin
      get_obs(k, oy, ny, qq, qv);
      check($sformatf("%s.out_y%0d", tag, k), oy, ext_of(k, a16));
      check($sformatf("%s.not_y%0d", tag, k), ny, inv_of(k, a16));
    end
  endtask

  task automatic check_reg(input string tag);
    logic [63:0] oy, ny, qq;
    logic qv;
    for (int k = 0; k < 3; k++) begin
      get_obs(k, oy, ny, qq, qv);
      check($sformatf("%s.q%0d", tag, k), qq, exp_q[k]);
      check($sformatf("%s.q_valid%0d", tag, k), {63'd0, qv}, {63'd0, exp_v[k]});
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      exp_q[k] = '0;
      exp_v[k] = 1'b0;
    end
  endtask

  // Drive at the falling edge, check combinational outputs, then check registers after the rising edge.
  task automatic step(input string tag, input logic [15:0] av, input logic opv, input logic vv);
    @(negedge clk);
    a16 = av;
    op  = opv;
    vld = vv;
    #1;
    check_comb(tag);
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < 3; k++) begin
        exp_v[k] = vv;
        if (vv) exp_q[k] = opv ? inv_of(k, av) : ext_of(k, av);
      end
    end
    check_reg(tag);
  endtask

  task automatic async_reset_pulse(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_reg(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reg("reset");
    step("reset_hold", 16'h00A5, 1'b1, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    step("v025", 16'h005A, 1'b1, 1'b1);
    step("v026", 16'h0004, 1'b0, 1'b1);
    step("v027", 16'h1234, 1'b0, 1'b1);
    step("v027i", 16'h1234, 1'b1, 1'b1);

    step("alt0", 16'h0000, 1'b1, 1'b1);
    step("alt1", 16'h0000, 1'b0, 1'b1);
    step("alt2", 16'h0000, 1'b1, 1'b1);
    step("idle", 16'hBEEF, 1'b0, 1'b0);

    async_reset_pulse("arst");
    step("rst_vld0", 16'h0033, 1'b1, 1'b1);
    step("rst_vld1", 16'h0044, 1'b0, 1'b1);
    rst = 1'b0;
    step("post_rst", 16'h0055, 1'b0, 1'b1);

    step("b00_op0", 16'h0000, 1'b0, 1'b1);
    step("b00_op1", 16'h0000, 1'b1, 1'b1);
    step("bff_op0", 16'h00FF, 1'b0, 1'b1);
    step("bff_op1", 16'h00FF, 1'b1, 1'b1);
    step("bffff", 16'hFFFF, 1'b1, 1'b1);

    for (int i = 0; i < 200; i++) begin
      step($sformatf("rnd%0d", i), 16'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 24) == 0) begin
        async_reset_pulse($sformatf("rnd_arst%0d", i));
        step($sformatf("rnd_inrst%0d", i), 16'($urandom), 1'($urandom), 1'b1);
        rst = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/not_output_a.md
NOT_OUTPUT_A -- requirements
Module: not_output_a

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the result width; values 8 and 32 SHALL be supported.
REQ-002 The block SHALL have parameter IN_WIDTH, default WIDTH, giving the operand width.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: the reset; it SHALL be asynchronous and active-high.
REQ-005 Port a, input, IN_WIDTH bits: the operand.
REQ-006 Port op, input, 1 bit: registered-path select; 0 = pass (OUTPUT_A), 1 = invert (NOT_A).
REQ-007 Port in_valid, input, 1 bit: qualifies a and op for capture.
REQ-008 Port not_y, output, WIDTH bits: combinational bitwise inverse of the extended operand.
REQ-009 Port out_y, output, WIDTH bits: combinational copy of the extended operand.
REQ-010 Port q, output, WIDTH bits: registered result selected by op.
REQ-011 Port q_valid, output, 1 bit: high for exactly the cycle(s) in which q holds a newly captured result.

Function
REQ-012 Width adaptation SHALL come first:
- IN_WIDTH < WIDTH: a is zero-extended to WIDTH.
- IN_WIDTH > WIDTH: only the low WIDTH bits of a are kept.
- Equal widths: a is passed unchanged.
REQ-013 out_y SHALL equal the extended operand, with zero delay cycles.
REQ-014 not_y SHALL equal the bitwise NOT of the extended operand, so zero-extended upper bits appear as 1s.
REQ-015 not_y and out_y SHALL be purely combinational and unaffected by clk, rst and in_valid.
REQ-016 On a rising clk edge with rst low and in_valid high:
- q SHALL load not_y if op=1, or out_y if op=0.
- q_valid SHALL be 1 on the following cycle.
REQ-017 Latency from in_valid to q/q_valid SHALL be exactly one clock cycle.
REQ-018 Back-to-back in_valid cycles SHALL produce back-to-back results with no bubbles. There is no backpressure.
REQ-019 On a rising clk edge with rst low and in_valid low, q SHALL hold its previous value and q_valid SHALL be 0.
REQ-020 Changes on a or op while in_valid is low SHALL NOT affect q.
REQ-021 The block SHALL contain no other state. op affects only the registered path.

Reset
REQ-022 When rst is high, q SHALL be 0 and q_valid SHALL be 0 immediately, without waiting for a clk edge.
REQ-023 rst asserted mid-stream SHALL discard any capture in that cycle. The first capture after rst deasserts SHALL occur on the first rising edge with rst low and in_valid high.
REQ-024 If rst and in_valid are high together, reset SHALL take priority.

Verification
REQ-025 WIDTH=8, IN_WIDTH=8, a=0x5A, op=1, in_valid=1 -> not_y=0xA5 and out_y=0x5A at once; one edge later q=0xA5, q_valid=1.
REQ-026 WIDTH=32, IN_WIDTH=8, a=0x04, op=0, in_valid=1 -> out_y=0x00000004, not_y=0xFFFFFFFB; next cycle q=0x00000004.
REQ-027 WIDTH=8, IN_WIDTH=16, a=0x1234 -> out_y=0x34, not_y=0xCB.
REQ-028 Alternating op over consecutive valid cycles with a=0x00, then in_valid low for one cycle:
- q sequence 0xFF, 0x00, 0xFF; q_valid=1 on each.
- In the idle cycle, q holds 0xFF and q_valid=0.
REQ-029 Assert rst asynchronously between edges while q=0xFF -> q=0x00 and q_valid=0 before the next edge. Hold in_valid=1 during rst -> no capture until rst is low.
REQ-030 Boundary operands a=0x00 and a=0xFF (WIDTH=8) with both op values -> q equals ~a or a exactly, and there is no carry or sign effect.
